usart_tx_fifo: RTL and testbench
================================

# usart_tx_fifo

Parametrised UART transmitter with a built-in transmit FIFO, configurable data width, runtime-selectable parity and one or two stop bits. It sits between a bus-side producer (CPU peripheral register or DMA) and the serial pin. It replaces the fixed 8N1 transmitter with a single-clock design that uses a bit-period enable counter instead of a derived clock, and accepts back-to-back words without gaps between frames.

## Interface
- DATA_BITS, 8, data bits per frame; legal range 5..9
- FIFO_DEPTH, 4, transmit FIFO entries; power of two, ≥2
- DIVIDER_WIDTH, 12, width of clocks_per_bit
- serial_clock  in  1  sole clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- clocks_per_bit  in  DIVIDER_WIDTH  bit period in serial_clock cycles; 0 and 1 both mean 1
- parity_mode  in  2  00 none, 01 even, 10 odd, 11 mark (parity bit always 1)
- two_stop_bits  in  1  1 = two stop bits, 0 = one
- data_in  in  DATA_BITS  word to transmit, LSB sent first
- valid  in  1  producer has a word on data_in
- ready  out  1  FIFO can accept a word (registered, not full)
- fifo_count  out  $clog2(FIFO_DEPTH)+1  words waiting in FIFO (excludes the word being shifted)
- busy  out  1  frame in progress or FIFO non-empty
- done  out  1  one-cycle pulse on the final cycle of the last stop bit
- tx_pin  out  1  serial output, idle high

## Operation
- Push: valid && ready at a rising edge writes data_in to the FIFO tail. valid with ready low is ignored; the producer holds data_in and valid until accepted.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: tx_pin=1. If the FIFO is non-empty, pop the head into the shift register and go to START. At the same edge, latch N=max(clocks_per_bit,1), parity_mode and two_stop_bits for the whole frame.
- START: tx_pin=0 for N cycles, then DATA.
- DATA: DATA_BITS bits, LSB first, N cycles each. Go to PARITY if latched parity_mode≠00, else STOP.
- PARITY: N cycles. Value: even = XOR of the data bits; odd = inverse of that; mark = 1.
- STOP: tx_pin=1 for N cycles, or 2N if two_stop_bits. On the last cycle, pulse done. If the FIFO is non-empty at that edge, pop and go directly to START (zero idle gap); otherwise go to IDLE.
- Bit timer: counter reloads at every state or bit boundary and counts 0..N-1. A boundary occurs when the count reaches N-1. DIVIDER_WIDTH arithmetic, no wrap past N-1.
- Config inputs changed mid-frame have no effect until the next frame start.
- Simultaneous push and pop: both take effect and fifo_count is unchanged. When full, ready is low even if a pop happens in the same cycle; there is no combinational path from valid to ready.
- FIFO pointers wrap modulo FIFO_DEPTH. The full/empty distinction uses fifo_count.

## Timing
- Reset (asynchronous, immediate, including mid-frame): tx_pin=1, ready=0, done=0, busy=0, fifo_count=0, state IDLE, FIFO emptied. The partial frame is abandoned; no done pulse.
- ready rises on the first edge after reset_n deasserts.
- Latency: word accepted at edge E0 into an empty FIFO while IDLE. Popped at E1, with tx_pin=0 from E1. fifo_count is 1 between E0 and E1.
- Frame length: (1 + DATA_BITS + P + S)·N cycles, where P = 0 or 1 and S = 1 or 2.
- done is high for exactly one cycle per frame, coincident with the final stop-bit cycle.
- ready updates one edge after a push or pop.

## Test plan
- 8N1, clocks_per_bit=4, push 0xA5 → tx_pin: 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then 1. Frame is 40 cycles; one done pulse on cycle 40; busy drops the cycle after.
- Parity: push 0x07 with parity_mode=01 → parity bit 1; with parity_mode=10 → parity bit 0; with parity_mode=11, push 0x00 → parity bit 1. Each frame is 44 cycles at N=4.
- Throughput: FIFO_DEPTH=4, clocks_per_bit=10, valid held with 6 distinct words on consecutive cycles → words 1–5 accepted; ready low after the 5th accept; 6th accepted after the first frame's pop. All 6 frames are contiguous with no idle high between stop and start; 6 done pulses.
- Divider edge: DATA_BITS=5, clocks_per_bit=0, two_stop_bits=1, no parity → frame is 8 cycles at one cycle per bit. Changing clocks_per_bit to 3 mid-frame does not alter that frame; the next frame uses N=3.
- Reset mid-frame: assert reset_n low during the DATA state with 2 words queued → tx_pin=1 immediately, fifo_count=0, no done pulse. After release, tx_pin stays high and ready=1 after one edge.

Source files
------------

// File: rtl/usart_tx_fifo.sv
// UART transmitter fed by a small FIFO; bit timing comes from a per-bit enable
// counter on the single serial clock, and queued words go out back-to-back.
module usart_tx_fifo #(
    parameter int unsigned DATA_BITS     = 8,
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned DIVIDER_WIDTH = 12
) (
    input  logic                         serial_clock,
    input  logic                         reset_n,
    input  logic [DIVIDER_WIDTH-1:0]     clocks_per_bit,
    input  logic [1:0]                   parity_mode,
    input  logic                         two_stop_bits,
    input  logic [DATA_BITS-1:0]         data_in,
    input  logic                         valid,
    output logic                         ready,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
    output logic                         busy,
    output logic                         done,
    output logic                         tx_pin
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned BW = $clog2(DATA_BITS);
    localparam int unsigned DW = DIVIDER_WIDTH;
    localparam logic [CW-1:0] FULL     = CW'(FIFO_DEPTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];

    state_t               state_q,  state_d;
    logic [DW-1:0]        cnt_q,    cnt_d;
    logic [DW-1:0]        n_q,      n_d;
    logic                 par_en_q, par_en_d;
    logic                 par_q,    par_d;
    logic                 two_q,    two_d;
    logic                 stop2_q,  stop2_d;
    logic [BW-1:0]        bit_q,    bit_d;
    logic [DATA_BITS-1:0] shift_q,  shift_d;
    logic [AW-1:0]        rd_q,     rd_d;
    logic [AW-1:0]        wr_q,     wr_d;
    logic [CW-1:0]        count_q,  count_d;
    logic                 ready_q,  ready_d;
    logic                 busy_q,   busy_d;
    logic                 done_q,   done_d;
    logic                 tx_q,     tx_d;

    logic                 push;
    logic                 pop;
    logic                 bnd;
    logic [DATA_BITS-1:0] head;

    assign ready      = ready_q;
    assign fifo_count = count_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign tx_pin     = tx_q;

    always_comb begin
        push     = valid && ready_q;
        pop      = 1'b0;
        head     = mem_q[rd_q];
        bnd      = (cnt_q == n_q - DW'(1));

        state_d  = state_q;
        cnt_d    = cnt_q;
        n_d      = n_q;
        par_en_d = par_en_q;
        par_d    = par_q;
        two_d    = two_q;
        stop2_d  = stop2_q;
        bit_d    = bit_q;
        shift_d  = shift_q;

        if (state_q != IDLE) begin
            cnt_d = bnd ? '0 : cnt_q + DW'(1);
        end

        unique case (state_q)
            IDLE: begin
                if (count_q != '0) pop = 1'b1;
            end
            START: begin
                if (bnd) begin
                    state_d = DATA;
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (bnd) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == LAST_BIT) begin
                        state_d = par_en_q ? PARITY : STOP;
                        stop2_d = 1'b0;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end
            end
            PARITY: begin
                if (bnd) begin
                    state_d = STOP;
                    stop2_d = 1'b0;
                end
            end
            STOP: begin
                if (bnd) begin
                    if (two_q && !stop2_q) begin
                        stop2_d = 1'b1;
                    end else if (count_q != '0) begin
                        pop = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Frame start: configuration is captured here and held for the whole frame.
        if (pop) begin
            state_d  = START;
            cnt_d    = '0;
            shift_d  = head;
            n_d      = (clocks_per_bit == '0) ? DW'(1) : clocks_per_bit;
            par_en_d = (parity_mode != 2'b00);
            two_d    = two_stop_bits;
            unique case (parity_mode)
                2'b01:   par_d = ^head;
                2'b10:   par_d = ~^head;
                default: par_d = 1'b1;
            endcase
        end

        rd_d    = pop  ? rd_q + AW'(1) : rd_q;
        wr_d    = push ? wr_q + AW'(1) : wr_q;
        count_d = count_q + CW'(push) - CW'(pop);
        ready_d = (count_d != FULL);
        busy_d  = (state_d != IDLE) || (count_d != '0);

        // Outputs are registered, so they are derived from the next-state values.
        done_d  = (state_d == STOP) && (cnt_d == n_d - DW'(1)) && (!two_d || stop2_d);
        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = par_d;
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge serial_clock) begin
        if (push) mem_q[wr_q] <= data_in;
    end

    always_ff @(posedge serial_clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            n_q      <= DW'(1);
            par_en_q <= 1'b0;
            par_q    <= 1'b0;
            two_q    <= 1'b0;
            stop2_q  <= 1'b0;
            bit_q    <= '0;
            shift_q  <= '0;
            rd_q     <= '0;
            wr_q     <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            tx_q     <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            n_q      <= n_d;
            par_en_q <= par_en_d;
            par_q    <= par_d;
            two_q    <= two_d;
            stop2_q  <= stop2_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            tx_q     <= tx_d;
        end
    end

endmodule

// File: tb/tb_usart_tx_fifo.sv
// Bench for usart_tx_fifo: queue-based frame model compared every cycle, plus
// literal waveform checks for the main scenarios and a DATA_BITS=5 instance.
module tb_usart_tx_fifo;

    logic        serial_clock = 1'b0;
    logic        reset_n = 1'b1;
    logic [11:0] cpb;
    logic [1:0]  pm;
    logic        two;
    logic [7:0]  data_in;
    logic        valid;
    logic        ready;
    logic [2:0]  fifo_count;
    logic        busy, done, tx_pin;

    logic [11:0] cpb5;
    logic [1:0]  pm5;
    logic        two5;
    logic [4:0]  data5;
    logic        valid5;
    logic        ready5;
    logic [2:0]  fifo_count5;
    logic        busy5, done5, tx5;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    always #5 serial_clock = ~serial_clock;

    usart_tx_fifo #(.DATA_BITS(8), .FIFO_DEPTH(4), .DIVIDER_WIDTH(12)) u_dut (
        .serial_clock(serial_clock), .reset_n(reset_n), .clocks_per_bit(cpb),
        .parity_mode(pm), .two_stop_bits(two), .data_in(data_in), .valid(valid),
        .ready(ready), .fifo_count(fifo_count), .busy(busy), .done(done), .tx_pin(tx_pin)
    );

    usart_tx_fifo #(.DATA_BITS(5), .FIFO_DEPTH(4), .DIVIDER_WIDTH(12)) u_dut5 (
        .serial_clock(serial_clock), .reset_n(reset_n), .clocks_per_bit(cpb5),
        .parity_mode(pm5), .two_stop_bits(two5), .data_in(data5), .valid(valid5),
        .ready(ready5), .fifo_count(fifo_count5), .busy(busy5), .done(done5), .tx_pin(tx5)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: words waiting, and the remaining per-cycle tx levels of the current frame.
    logic [7:0] mq[$];
    bit         fq[$];
    bit         m_ready = 1'b0;

    task automatic add_bits(input bit v, input int n);
        for (int r = 0; r < n; r++) fq.push_back(v);
    endtask

    task automatic build_frame(input logic [7:0] w);
        int n;
        n = (cpb == 12'd0) ? 1 : int'(cpb);
        add_bits(1'b0, n);
        for (int i = 0; i < 8; i++) add_bits(w[i], n);
        if (pm == 2'b01) add_bits(^w, n);
        else if (pm == 2'b10) add_bits(~^w, n);
        else if (pm == 2'b11) add_bits(1'b1, n);
        add_bits(1'b1, two ? 2 * n : n);
    endtask

    always @(posedge serial_clock or negedge reset_n) begin
        if (!reset_n) begin
            mq.delete();
            fq.delete();
            m_ready = 1'b0;
        end else begin
            bit         do_push;
            logic [7:0] w;
            do_push = valid && m_ready;
            w       = data_in;
            if (fq.size() > 0) void'(fq.pop_front());
            if (fq.size() == 0 && mq.size() > 0) build_frame(mq.pop_front());
            if (do_push) mq.push_back(w);
            m_ready = (mq.size() < 4);
        end
    end

    always @(negedge serial_clock) begin
        if (cmp_en) begin
            check("tx_pin", tx_pin, (fq.size() > 0) ? fq[0] : 1'b1);
            check("done", done, fq.size() == 1);
            check("busy", busy, (fq.size() > 0) || (mq.size() > 0));
            check("fifo_count", fifo_count, mq.size());
            check("ready", ready, m_ready);
        end
    end

    // Call at a negedge; returns at the negedge after the accepting edge with valid still high.
    task automatic push(input logic [7:0] w);
        int t;
        data_in = w;
        valid   = 1'b1;
        t = 0;
        while (!ready && t < 5000) begin
            @(negedge serial_clock);
            t++;
        end
        if (!ready) begin
            check("push_timeout", ready, 1'b1);
            valid = 1'b0;
        end else begin
            @(negedge serial_clock);
        end
    endtask

    task automatic capture(input bit sel, input int n, input int chg_at, input logic [11:0] chg_val,
                           output int len, output logic [15:0] bits);
        int t;
        len  = -1;
        bits = '0;
        t    = 0;
        while ((sel ? tx5 : tx_pin) !== 1'b0 && t < 1000) begin
            @(negedge serial_clock);
            t++;
        end
        for (int k = 0; k < 2000; k++) begin
            if (sel && k == chg_at) cpb5 = chg_val;
            if ((k % n) == (n / 2) && (k / n) < 16) bits[k / n] = sel ? tx5 : tx_pin;
            if ((sel ? done5 : done) === 1'b1) begin
                len = k + 1;
                break;
            end
            @(negedge serial_clock);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int          len;
        logic [15:0] bits;
        int          ndone, tlen, t;

        valid = 1'b0; data_in = '0; cpb = 12'd4; pm = 2'b00; two = 1'b0;
        valid5 = 1'b0; data5 = '0; cpb5 = 12'd0; pm5 = 2'b00; two5 = 1'b1;

        #1 reset_n = 1'b0;
        #1 cmp_en = 1'b1;
        check("rst_tx", tx_pin, 1'b1);
        check("rst_ready", ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_count", fifo_count, 3'd0);
        check("rst_done", done, 1'b0);
        repeat (2) @(negedge serial_clock);
        reset_n = 1'b1;
        @(negedge serial_clock);
        check("ready_after_reset", ready, 1'b1);
        check("ready5_after_reset", ready5, 1'b1);

        // 8N1 at N=4
        push(8'hA5);
        valid = 1'b0;
        capture(1'b0, 4, -1, 12'd0, len, bits);
        check("8n1_len", len, 40);
        check("8n1_bits", bits[9:0], 10'h34A);
        @(negedge serial_clock);
        check("8n1_busy_after", busy, 1'b0);

        // Parity variants at N=4
        pm = 2'b01;
        push(8'h07);
        valid = 1'b0;
        capture(1'b0, 4, -1, 12'd0, len, bits);
        check("even_len", len, 44);
        check("even_bits", bits[10:0], 11'h60E);
        pm = 2'b10;
        push(8'h07);
        valid = 1'b0;
        capture(1'b0, 4, -1, 12'd0, len, bits);
        check("odd_len", len, 44);
        check("odd_bits", bits[10:0], 11'h40E);
        pm = 2'b11;
        push(8'h00);
        valid = 1'b0;
        capture(1'b0, 4, -1, 12'd0, len, bits);
        check("mark_len", len, 44);
        check("mark_bits", bits[10:0], 11'h600);
        @(negedge serial_clock);

        // Throughput: six words back-to-back, N=10
        pm = 2'b00; cpb = 12'd10;
        ndone = 0; tlen = -1;
        fork
            begin
                push(8'h11); push(8'h22); push(8'h33); push(8'h44); push(8'h55);
                check("ready_low_when_full", ready, 1'b0);
                push(8'h66);
                valid = 1'b0;
            end
            begin
                t = 0;
                while (tx_pin !== 1'b0 && t < 100) begin
                    @(negedge serial_clock);
                    t++;
                end
                for (int k = 0; k < 2000; k++) begin
                    if (done === 1'b1) ndone++;
                    if (ndone == 6) begin
                        tlen = k + 1;
                        break;
                    end
                    @(negedge serial_clock);
                end
            end
        join
        check("thru_done_pulses", ndone, 6);
        check("thru_total_cycles", tlen, 600);
        @(negedge serial_clock);

        // DATA_BITS=5, N=1, two stop bits; divider change mid-frame applies next frame
        data5 = 5'b10110; valid5 = 1'b1;
        @(negedge serial_clock);
        valid5 = 1'b0;
        capture(1'b1, 1, 3, 12'd3, len, bits);
        check("div_len_n1", len, 8);
        check("div_bits_n1", bits[7:0], 8'hEC);
        @(negedge serial_clock);
        data5 = 5'b01001; valid5 = 1'b1;
        @(negedge serial_clock);
        valid5 = 1'b0;
        capture(1'b1, 3, -1, 12'd0, len, bits);
        check("div_len_n3", len, 24);
        check("div_bits_n3", bits[7:0], 8'hD2);

        // Randomized traffic with changing configuration
        for (int i = 0; i < 150; i++) begin
            cpb = 12'($urandom_range(0, 5));
            pm  = 2'($urandom_range(0, 3));
            two = 1'($urandom_range(0, 1));
            push(8'($urandom_range(0, 255)));
            if ($urandom_range(0, 3) == 0) begin
                valid = 1'b0;
                repeat ($urandom_range(1, 30)) @(negedge serial_clock);
            end
        end
        valid = 1'b0;
        t = 0;
        while (busy && t < 20000) begin
            @(negedge serial_clock);
            t++;
        end
        check("drain_idle", busy, 1'b0);

        // Reset during DATA with two words queued
        cpb = 12'd4; pm = 2'b00; two = 1'b0;
        push(8'h3C); push(8'hC3); push(8'h5A);
        valid = 1'b0;
        repeat (10) @(negedge serial_clock);
        check("pre_reset_count", fifo_count, 3'd2);
        #1 reset_n = 1'b0;
        #1;
        check("midrst_tx", tx_pin, 1'b1);
        check("midrst_count", fifo_count, 3'd0);
        check("midrst_done", done, 1'b0);
        check("midrst_ready", ready, 1'b0);
        repeat (2) @(negedge serial_clock);
        reset_n = 1'b1;
        @(negedge serial_clock);
        check("post_rst_ready", ready, 1'b1);
        check("post_rst_tx", tx_pin, 1'b1);
        repeat (5) @(negedge serial_clock);
        check("post_rst_idle_tx", tx_pin, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
